// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Sequential pipeline hazard controller for the RV32I 5-stage core.
//            Detects load-use hazards between ID and EX, holds the PC and
//            IF/ID register for a configurable number of cycles (optionally
//            until the data memory responds), and sequences the IF/DEC kill
//            signals after a control redirect. Keeps saturating counts of
//            stall cycles and redirect events.
// Ports    : clk, rst_n                 - clock, asynchronous active-low reset
//            id_valid/opcode/rs1/rs2    - instruction currently in ID
//            ex_valid/mem_read/rd       - instruction currently in EX
//            mem_ready                  - data-memory response (WAIT_MEM=1)
//            ex_redirect                - taken branch / JAL / JALR in EX
//            stall_IF, stall_DEC        - hold PC / hold IF/ID
//            kill_IF, kill_DEC          - NOP IF/ID / bubble into ID/EX
//            busy                       - controller not idle
//            stall_count, flush_count   - saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int LOAD_LAT    = 1,
    parameter int WAIT_MEM    = 0,
    parameter int FLUSH_EXTRA = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_ready,
    input  logic             ex_redirect,
    output logic             stall_IF,
    output logic             stall_DEC,
    output logic             kill_IF,
    output logic             kill_DEC,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_STALL   = 2'd1;
    localparam logic [1:0] c_MEMWAIT = 2'd2;
    localparam logic [1:0] c_FLUSH   = 2'd3;

    // Where a load-use stall goes once its fixed latency has elapsed.
    localparam logic [1:0] c_AFTER_STALL = (WAIT_MEM != 0) ? c_MEMWAIT : c_IDLE;
    // Where a redirect goes: no FLUSH state is entered when no extra kill
    // cycles are configured.
    localparam logic [1:0] c_AFTER_REDIR = (FLUSH_EXTRA > 0) ? c_FLUSH : c_IDLE;

    localparam logic [3:0] c_LOAD_CNT  = 4'(LOAD_LAT - 1);
    localparam logic [3:0] c_FLUSH_CNT = 4'(FLUSH_EXTRA);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_use_rs1;
    logic w_use_rs2;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;
    logic w_stall;
    logic w_kill_if;
    logic w_kill_dec;

    // Which register fields are real sources depends on the format; the rd
    // field of B/S-type instructions overlaps rs-like bits and must be ignored.
    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (id_opcode)
            c_OP_R, c_OP_STORE, c_OP_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            c_OP_IMM, c_OP_LOAD, c_OP_JALR: begin
                w_use_rs1 = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w_rs1_hit  = w_use_rs1 && (id_rs1 != '0) && (id_rs1 == ex_rd);
    assign w_rs2_hit  = w_use_rs2 && (id_rs2 != '0) && (id_rs2 == ex_rd);
    assign w_load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != '0)
                        && (w_rs1_hit || w_rs2_hit);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; a redirect pre-empts every state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (ex_redirect) begin
            w_state_nxt = c_AFTER_REDIR;
            w_cnt_nxt   = c_FLUSH_CNT;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_load_use) begin
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = c_STALL;
                            w_cnt_nxt   = c_LOAD_CNT;
                        end else begin
                            w_state_nxt = c_AFTER_STALL;
                            w_cnt_nxt   = 4'd0;
                        end
                    end
                end
                c_STALL: begin
                    // The IDLE detection cycle is stall cycle 1, so STALL
                    // covers the remaining LOAD_LAT-1 cycles.
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = c_AFTER_STALL;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                c_MEMWAIT: begin
                    if (mem_ready) begin
                        w_state_nxt = c_IDLE;
                    end
                end
                c_FLUSH: begin
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Output logic: combinational from state and inputs, forced low while
    // reset is held so the pipeline sees no stray hold/kill.
    always_comb begin
        w_stall    = 1'b0;
        w_kill_if  = 1'b0;
        w_kill_dec = 1'b0;
        if (rst_n) begin
            if (ex_redirect) begin
                w_kill_if  = 1'b1;
                w_kill_dec = 1'b1;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_load_use) begin
                            w_stall    = 1'b1;
                            w_kill_dec = 1'b1;
                        end
                    end
                    c_STALL: begin
                        w_stall    = 1'b1;
                        w_kill_dec = 1'b1;
                    end
                    c_MEMWAIT: begin
                        if (!mem_ready) begin
                            w_stall    = 1'b1;
                            w_kill_dec = 1'b1;
                        end
                    end
                    c_FLUSH: begin
                        w_kill_if = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign stall_IF  = w_stall;
    assign stall_DEC = w_stall;
    assign kill_IF   = w_kill_if;
    assign kill_DEC  = w_kill_dec;
    assign busy      = rst_n && (r_state != c_IDLE);

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (ex_redirect && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Scoreboard bench for hazard_ctrl. Four instances with different
//            parameter sets share one stimulus bus; each expected record names
//            the instance it applies to. Stimulus pushes expectations, a
//            monitor on the falling edge pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hazard_ctrl;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // {stall_IF, stall_DEC, kill_IF, kill_DEC, busy}
    localparam logic [4:0] O_NONE   = 5'b00000;
    localparam logic [4:0] O_STALL  = 5'b11010;
    localparam logic [4:0] O_STALLB = 5'b11011;
    localparam logic [4:0] O_KILL   = 5'b00110;
    localparam logic [4:0] O_KILLB  = 5'b00111;
    localparam logic [4:0] O_KIFB   = 5'b00101;
    localparam logic [4:0] M_ALL    = 5'b11111;
    localparam logic [4:0] M_NOBUSY = 5'b11110;

    typedef struct {
        int          sel;
        logic [4:0]  out;
        logic [4:0]  mask;
        logic [15:0] sc;
        logic [15:0] fc;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [6:0] id_opcode = '0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       ex_valid = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       mem_ready = 1'b0;
    logic       ex_redirect = 1'b0;

    logic sif0, sdec0, kif0, kdec0, bsy0;
    logic sif1, sdec1, kif1, kdec1, bsy1;
    logic sif2, sdec2, kif2, kdec2, bsy2;
    logic sif3, sdec3, kif3, kdec3, bsy3;
    logic [15:0] sc0, fc0, sc1, fc1, sc2, fc2;
    logic [3:0]  sc3, fc3;

    always #5 clk = ~clk;

    // 0: LOAD_LAT=1 ; 1: LOAD_LAT=3 + WAIT_MEM ; 2: LOAD_LAT=4 + FLUSH_EXTRA=2
    // 3: LOAD_LAT=1 with 4-bit counters
    hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .WAIT_MEM(0), .FLUSH_EXTRA(0), .CNT_W(16)) u_d0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .mem_ready(mem_ready), .ex_redirect(ex_redirect),
        .stall_IF(sif0), .stall_DEC(sdec0), .kill_IF(kif0), .kill_DEC(kdec0), .busy(bsy0),
        .stall_count(sc0), .flush_count(fc0));
    hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .WAIT_MEM(1), .FLUSH_EXTRA(0), .CNT_W(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .mem_ready(mem_ready), .ex_redirect(ex_redirect),
        .stall_IF(sif1), .stall_DEC(sdec1), .kill_IF(kif1), .kill_DEC(kdec1), .busy(bsy1),
        .stall_count(sc1), .flush_count(fc1));
    hazard_ctrl #(.REG_W(5), .LOAD_LAT(4), .WAIT_MEM(0), .FLUSH_EXTRA(2), .CNT_W(16)) u_d2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .mem_ready(mem_ready), .ex_redirect(ex_redirect),
        .stall_IF(sif2), .stall_DEC(sdec2), .kill_IF(kif2), .kill_DEC(kdec2), .busy(bsy2),
        .stall_count(sc2), .flush_count(fc2));
    hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .WAIT_MEM(0), .FLUSH_EXTRA(0), .CNT_W(4)) u_d3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .mem_ready(mem_ready), .ex_redirect(ex_redirect),
        .stall_IF(sif3), .stall_DEC(sdec3), .kill_IF(kif3), .kill_DEC(kdec3), .busy(bsy3),
        .stall_count(sc3), .flush_count(fc3));

    // Apply one cycle of inputs, 1 ns after the rising edge.
    task automatic drive(input logic idv, input logic [6:0] opc, input logic [4:0] r1,
                         input logic [4:0] r2, input logic exv, input logic mrd,
                         input logic [4:0] rd, input logic mrdy, input logic redir);
        @(posedge clk);
        #1;
        id_valid    = idv;
        id_opcode   = opc;
        id_rs1      = r1;
        id_rs2      = r2;
        ex_valid    = exv;
        ex_mem_read = mrd;
        ex_rd       = rd;
        mem_ready   = mrdy;
        ex_redirect = redir;
    endtask

    task automatic idle_in();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic lu10();
        // addi-type use of x10 while lw x10 sits in EX
        drive(1'b1, OP_IMM, 5'd10, 5'd0, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0);
    endtask

    task automatic expm(input int sel, input logic [4:0] o, input logic [4:0] m,
                        input logic [15:0] sc, input logic [15:0] fc, input string nm);
        exp_t e;
        e.sel = sel; e.out = o; e.mask = m; e.sc = sc; e.fc = fc; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic expect_out(input int sel, input logic [4:0] o,
                              input logic [15:0] sc, input logic [15:0] fc, input string nm);
        expm(sel, o, M_ALL, sc, fc, nm);
    endtask

    task automatic reset_all();
        idle_in();
        rst_n = 1'b0;
        idle_in();
        rst_n = 1'b1;
    endtask

    // Monitor: compares the selected instance whenever an expectation is queued.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [4:0]  act;
        logic [15:0] asc;
        logic [15:0] afc;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.sel)
                0: begin act = {sif0, sdec0, kif0, kdec0, bsy0}; asc = sc0; afc = fc0; end
                1: begin act = {sif1, sdec1, kif1, kdec1, bsy1}; asc = sc1; afc = fc1; end
                2: begin act = {sif2, sdec2, kif2, kdec2, bsy2}; asc = sc2; afc = fc2; end
                default: begin
                    act = {sif3, sdec3, kif3, kdec3, bsy3};
                    asc = {12'd0, sc3};
                    afc = {12'd0, fc3};
                end
            endcase
            total++;
            if ((((act ^ e.out) & e.mask) != 5'd0) || (asc != e.sc) || (afc != e.fc)) begin
                bad++;
                $display("FAIL %s: got out=%b sc=%0d fc=%0d, want out=%b (mask %b) sc=%0d fc=%0d",
                         e.name, act, asc, afc, e.out, e.mask, e.sc, e.fc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // ---------------- instance 0: LOAD_LAT=1 ----------------
        drive(1'b1, OP_R, 5'd11, 5'd0, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0);
        expect_out(0, O_NONE, 0, 0, "reset_gates_outputs");
        idle_in();
        rst_n = 1'b1;
        expect_out(0, O_NONE, 0, 0, "reset_release_idle");

        drive(1'b1, OP_IMM, 5'd0, 5'd2, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0);
        expect_out(0, O_NONE, 0, 0, "addi_vs_lw_x10");
        drive(1'b1, OP_IMM, 5'd0, 5'd2, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
        expect_out(0, O_NONE, 0, 0, "addi_rs2_field_unused");
        drive(1'b1, OP_BR, 5'd10, 5'd11, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
        expect_out(0, O_NONE, 0, 0, "beq_rd_field_not_src");
        drive(1'b1, OP_BR, 5'd10, 5'd11, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0);
        expect_out(0, O_STALL, 0, 0, "beq_rs2_hazard");
        drive(1'b1, OP_BR, 5'd10, 5'd11, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out(0, O_NONE, 1, 0, "single_cycle_stall_done");
        drive(1'b1, OP_LUI, 5'd11, 5'd11, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0);
        expect_out(0, O_NONE, 1, 0, "lui_no_sources");
        drive(1'b1, OP_R, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out(0, O_NONE, 1, 0, "x0_never_matches");
        drive(1'b1, OP_ST, 5'd5, 5'd11, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0);
        expect_out(0, O_STALL, 1, 0, "store_rs2_hazard");
        drive(1'b1, OP_JAL, 5'd11, 5'd11, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0);
        expect_out(0, O_NONE, 2, 0, "jal_no_sources");
        drive(1'b0, OP_R, 5'd11, 5'd0, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0);
        expect_out(0, O_NONE, 2, 0, "id_invalid_no_stall");
        drive(1'b1, OP_R, 5'd11, 5'd0, 1'b1, 1'b1, 5'd11, 1'b0, 1'b1);
        expect_out(0, O_KILL, 2, 0, "redirect_beats_load_use");
        idle_in();
        expect_out(0, O_NONE, 2, 1, "after_redirect_idle");

        // ---------------- instance 1: LOAD_LAT=3, WAIT_MEM=1 ----------------
        reset_all();
        expect_out(1, O_NONE, 0, 0, "b_reset");
        lu10();
        expect_out(1, O_STALL, 0, 0, "b_stall_c1");
        drive(1'b1, OP_IMM, 5'd10, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out(1, O_STALLB, 1, 0, "b_stall_c2");
        drive(1'b1, OP_IMM, 5'd10, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out(1, O_STALLB, 2, 0, "b_stall_c3");
        drive(1'b1, OP_IMM, 5'd10, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out(1, O_STALLB, 3, 0, "b_memwait_c4");
        drive(1'b1, OP_IMM, 5'd10, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out(1, O_STALLB, 4, 0, "b_memwait_c5");
        drive(1'b1, OP_IMM, 5'd10, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        expm(1, O_NONE, M_NOBUSY, 5, 0, "b_mem_ready_release");
        idle_in();
        expect_out(1, O_NONE, 5, 0, "b_back_to_idle");

        // ---------------- instance 2: LOAD_LAT=4, FLUSH_EXTRA=2 ----------------
        reset_all();
        expect_out(2, O_NONE, 0, 0, "c_reset");
        lu10();
        expect_out(2, O_STALL, 0, 0, "c_stall_c1");
        drive(1'b1, OP_IMM, 5'd10, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        expect_out(2, O_KILLB, 1, 0, "c_redirect_aborts_stall");
        lu10();
        expect_out(2, O_KIFB, 1, 1, "c_flush1_ignores_load_use");
        drive(1'b1, OP_IMM, 5'd10, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out(2, O_KIFB, 1, 1, "c_flush2");
        drive(1'b1, OP_IMM, 5'd10, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out(2, O_NONE, 1, 1, "c_idle_after_flush");
        drive(1'b0, 7'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        expect_out(2, O_KILL, 1, 1, "c_redirect_from_idle");
        drive(1'b0, 7'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        expect_out(2, O_KILLB, 1, 2, "c_redirect_in_flush");
        idle_in();
        expect_out(2, O_KIFB, 1, 3, "c_restart_flush1");
        idle_in();
        expect_out(2, O_KIFB, 1, 3, "c_restart_flush2");
        idle_in();
        expect_out(2, O_NONE, 1, 3, "c_idle_after_restart");

        // Asynchronous reset in the middle of a STALL
        reset_all();
        lu10();
        expect_out(2, O_STALL, 0, 0, "e_stall_c1");
        lu10();
        expect_out(2, O_STALLB, 1, 0, "e_stall_c2");
        lu10();
        #1;
        rst_n = 1'b0;
        expect_out(2, O_NONE, 0, 0, "e_async_reset_mid_stall");
        idle_in();
        rst_n = 1'b1;
        expect_out(2, O_NONE, 0, 0, "e_after_release");
        lu10();
        expect_out(2, O_STALL, 0, 0, "e_fresh_stall_from_idle");

        // ---------------- instance 3: 4-bit counter saturation ----------------
        reset_all();
        for (int i = 0; i < 20; i++) begin
            lu10();
            expect_out(3, O_STALL, (i < 15) ? 16'(i) : 16'd15, 0, $sformatf("d_sat_%0d", i));
        end
        idle_in();
        expect_out(3, O_NONE, 15, 0, "d_saturated_hold");

        repeat (2) @(posedge clk);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
